// File: rtl/ws2812_pixel_tx.sv
`default_nettype none
// ============================================================================
// ws2812_pixel_tx : FIFO-buffered GRB pixel serialiser for WS2812 strings.
// Optional macro WS2812_TX_STATS_EN adds frame/underrun counters.  Rev 1.0
// ============================================================================
module ws2812_pixel_tx #(
  parameter int FIFO_AW   = 4,
  parameter int T0H_CYC   = 20,
  parameter int T1H_CYC   = 40,
  parameter int BIT_CYC   = 63,
  parameter int LATCH_CYC = 15000
) (
  input  logic               clk_clk,
  input  logic               reset_reset_n,
  input  logic [23:0]        pix_data,
  input  logic               pix_last,
  input  logic               pix_valid,
  output logic               pix_ready,
  output logic               led_dout,
  output logic               busy,
  output logic [FIFO_AW:0]   fifo_level,
`ifdef WS2812_TX_STATS_EN
  output logic [15:0]        frame_cnt,
  output logic [15:0]        underrun_cnt,
`endif
  output logic               underrun
);

  localparam int c_DEPTH = 2 ** FIFO_AW;
  localparam int c_CMAX  = (BIT_CYC > LATCH_CYC) ? BIT_CYC : LATCH_CYC;
  localparam int c_CW    = $clog2(c_CMAX + 1);

  localparam logic [c_CW-1:0]  c_ONE   = c_CW'(1);
  localparam logic [c_CW-1:0]  c_T0H   = c_CW'(T0H_CYC);
  localparam logic [c_CW-1:0]  c_T1H   = c_CW'(T1H_CYC);
  localparam logic [c_CW-1:0]  c_T0L   = c_CW'(BIT_CYC - T0H_CYC);
  localparam logic [c_CW-1:0]  c_T1L   = c_CW'(BIT_CYC - T1H_CYC);
  localparam logic [c_CW-1:0]  c_LATCH = c_CW'(LATCH_CYC);
  localparam logic [FIFO_AW:0] c_FULL  = {1'b1, {FIFO_AW{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HIGH  = 2'd1,
    S_LOW   = 2'd2,
    S_LATCH = 2'd3
  } state_t;

  // ---------------- FIFO of {last, data} ----------------
  logic [24:0]      r_mem [c_DEPTH];
  logic [FIFO_AW:0] r_wr_ptr;
  logic [FIFO_AW:0] r_rd_ptr;
  logic [FIFO_AW:0] r_level;
  logic [FIFO_AW:0] w_level_nx;
  logic             r_ready;
  logic             w_push;
  logic             w_pop;
  logic             w_empty;
  logic [24:0]      w_head;

  assign w_push  = pix_valid && r_ready;
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_head  = r_mem[r_rd_ptr[FIFO_AW-1:0]];

  always_ff @(posedge clk_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[FIFO_AW-1:0]] <= {pix_last, pix_data};
    end
  end

  always_comb begin
    w_level_nx = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_nx = r_level + 1'b1;
      2'b01:   w_level_nx = r_level - 1'b1;
      default: w_level_nx = r_level;
    endcase
  end

  // Ready is registered from the next level so it never forms a comb path.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ready  <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level <= w_level_nx;
      r_ready <= (w_level_nx != c_FULL);
    end
  end

  // ---------------- Bit serialiser FSM ----------------
  state_t          r_state;
  state_t          w_state_nx;
  logic [c_CW-1:0] r_cnt;
  logic [c_CW-1:0] w_cnt_nx;
  logic [23:0]     r_shift;
  logic [23:0]     w_shift_nx;
  logic [4:0]      r_idx;
  logic [4:0]      w_idx_nx;
  logic            r_last;
  logic            w_last_nx;
  logic            w_underrun_nx;
  logic            r_underrun;
  logic            r_led;
  logic [c_CW-1:0] w_head_hi;

  assign w_head_hi = w_head[23] ? c_T1H : c_T0H;

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_shift    <= '0;
      r_idx      <= '0;
      r_last     <= 1'b0;
      r_underrun <= 1'b0;
      r_led      <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_cnt      <= w_cnt_nx;
      r_shift    <= w_shift_nx;
      r_idx      <= w_idx_nx;
      r_last     <= w_last_nx;
      r_underrun <= w_underrun_nx;
      r_led      <= (w_state_nx == S_HIGH);
    end
  end

  always_comb begin
    w_state_nx    = r_state;
    w_cnt_nx      = r_cnt;
    w_shift_nx    = r_shift;
    w_idx_nx      = r_idx;
    w_last_nx     = r_last;
    w_pop         = 1'b0;
    w_underrun_nx = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop      = 1'b1;
          w_shift_nx = w_head[23:0];
          w_last_nx  = w_head[24];
          w_idx_nx   = 5'd23;
          w_cnt_nx   = w_head_hi;
          w_state_nx = S_HIGH;
        end
      end
      S_HIGH: begin
        if (r_cnt == c_ONE) begin
          w_cnt_nx   = r_shift[23] ? c_T1L : c_T0L;
          w_state_nx = S_LOW;
        end else begin
          w_cnt_nx = r_cnt - c_ONE;
        end
      end
      S_LOW: begin
        if (r_cnt != c_ONE) begin
          w_cnt_nx = r_cnt - c_ONE;
        end else if (r_idx != 5'd0) begin
          w_shift_nx = {r_shift[22:0], 1'b0};
          w_idx_nx   = r_idx - 5'd1;
          w_cnt_nx   = r_shift[22] ? c_T1H : c_T0H;
          w_state_nx = S_HIGH;
        end else if (r_last) begin
          w_cnt_nx   = c_LATCH;
          w_state_nx = S_LATCH;
        end else if (!w_empty) begin
          // Next pixel follows with no gap so bit spacing stays exact.
          w_pop      = 1'b1;
          w_shift_nx = w_head[23:0];
          w_last_nx  = w_head[24];
          w_idx_nx   = 5'd23;
          w_cnt_nx   = w_head_hi;
          w_state_nx = S_HIGH;
        end else begin
          w_underrun_nx = 1'b1;
          w_cnt_nx      = c_LATCH;
          w_state_nx    = S_LATCH;
        end
      end
      S_LATCH: begin
        if (r_cnt == c_ONE) begin
          w_state_nx = S_IDLE;
        end else begin
          w_cnt_nx = r_cnt - c_ONE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  assign pix_ready  = r_ready;
  assign led_dout   = r_led;
  assign busy       = (r_state != S_IDLE) || !w_empty;
  assign fifo_level = r_level;
  assign underrun   = r_underrun;

`ifdef WS2812_TX_STATS_EN
  logic [15:0] r_frame_cnt;
  logic [15:0] r_underrun_cnt;
  logic        w_latch_entry;

  assign w_latch_entry = (w_state_nx == S_LATCH) && (r_state != S_LATCH);

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      r_frame_cnt    <= '0;
      r_underrun_cnt <= '0;
    end else begin
      if (w_latch_entry) r_frame_cnt    <= r_frame_cnt + 16'd1;
      if (w_underrun_nx) r_underrun_cnt <= r_underrun_cnt + 16'd1;
    end
  end

  assign frame_cnt    = r_frame_cnt;
  assign underrun_cnt = r_underrun_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ws2812_pixel_tx.sv
`default_nettype none
// ============================================================================
// tb_ws2812_pixel_tx : waveform-queue reference model plus directed/random runs.
// Rev 1.0
// ============================================================================
module tb_ws2812_pixel_tx;

  localparam int BITC  = 63;
  localparam int T0H   = 20;
  localparam int T1H   = 40;
  localparam int LATCH = 15000;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] data;
  logic        last;
  logic        valid;
  logic        pix_ready;
  logic        led_dout;
  logic        busy;
  logic [4:0]  fifo_level;
  logic        underrun;
`ifdef WS2812_TX_STATS_EN
  logic [15:0] frame_cnt;
  logic [15:0] underrun_cnt;
`endif

  always #5 clk = ~clk;

  ws2812_pixel_tx dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .pix_data      (data),
    .pix_last      (last),
    .pix_valid     (valid),
    .pix_ready     (pix_ready),
    .led_dout      (led_dout),
    .busy          (busy),
    .fifo_level    (fifo_level),
`ifdef WS2812_TX_STATS_EN
    .frame_cnt     (frame_cnt),
    .underrun_cnt  (underrun_cnt),
`endif
    .underrun      (underrun)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  // ---------------- Reference model ----------------
  typedef struct packed { logic l; logic [23:0] d; } word_t;
  word_t  mq[$];
  bit     wave[$];
  int     mode;        // 0 idle, 1 sending pixels, 2 latch gap
  bit     m_cur_last;
  bit     m_ready;
  bit     m_under;
  bit     m_acc;
  bit     m_led;
  bit     m_busy;
  int     m_frames;
  int     m_unders;
  int     pre;
  longint cyc = 0;

  function automatic void load_word(input word_t w);
    for (int b = 23; b >= 0; b--)
      for (int c = 0; c < BITC; c++)
        wave.push_back(c < (w.d[b] ? T1H : T0H));
    m_cur_last = w.l;
  endfunction

  function automatic void enter_latch();
    for (int c = 0; c < LATCH; c++) wave.push_back(1'b0);
    mode = 2;
    m_frames++;
  endfunction

  always @(posedge clk) begin
    cyc++;
    m_under = 1'b0;
    m_acc   = 1'b0;
    if (!rst_n) begin
      mq.delete();
      wave.delete();
      mode     = 0;
      m_ready  = 1'b0;
      m_frames = 0;
      m_unders = 0;
    end else begin
      pre = mq.size();
      if (wave.size() == 0) begin
        case (mode)
          0: if (pre > 0) begin load_word(mq.pop_front()); mode = 1; end
          1: begin
            if (m_cur_last) enter_latch();
            else if (pre > 0) load_word(mq.pop_front());
            else begin m_under = 1'b1; m_unders++; enter_latch(); end
          end
          default: mode = 0;
        endcase
      end
      if (valid && m_ready) begin
        mq.push_back({last, data});
        m_acc = 1'b1;
      end
      m_ready = (mq.size() != DEPTH);
    end
    m_led  = (wave.size() > 0) ? wave.pop_front() : 1'b0;
    m_busy = (mode != 0) || (mq.size() > 0);
    #1;
    chk($sformatf("cycle %0d {led,ready,busy,level,underrun}", cyc),
        {led_dout, pix_ready, busy, fifo_level, underrun},
        {m_led, m_ready, m_busy, 5'(mq.size()), m_under});
`ifdef WS2812_TX_STATS_EN
    chk($sformatf("cycle %0d frame_cnt", cyc), frame_cnt, 16'(m_frames));
    chk($sformatf("cycle %0d underrun_cnt", cyc), underrun_cnt, 16'(m_unders));
`endif
  end

  // Rise / underrun timestamps sampled mid-cycle.
  longint rise_t[$];
  longint under_t[$];
  bit     prev_led = 1'b0;
  always @(negedge clk) begin
    if (led_dout === 1'b1 && !prev_led) rise_t.push_back(cyc);
    if (underrun === 1'b1) under_t.push_back(cyc);
    prev_led = (led_dout === 1'b1);
  end

  // ---------------- Stimulus helpers ----------------
  task automatic push(input logic [23:0] d, input logic l);
    int t = 0;
    valid = 1'b1;
    data  = d;
    last  = l;
    do begin
      @(negedge clk);
      t++;
    end while (!m_acc && t < 40000);
    if (!m_acc) chk("push accept timeout", 0, 1);
    valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int t = 0;
    while (busy && t < bound) begin
      @(negedge clk);
      t++;
    end
    if (busy) chk("wait for busy low timeout", 1, 0);
  endtask

  int highs;
  int rises;
  int bad;
  int g;

  initial begin
    rst_n = 1'b0;
    valid = 1'b0;
    data  = '0;
    last  = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset led_dout", led_dout, 0);
    chk("reset pix_ready", pix_ready, 0);
    chk("reset busy", busy, 0);
    chk("reset fifo_level", fifo_level, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single pixel 0xFF0000 with last=1.
    rise_t.delete();
    push(24'hFF0000, 1'b1);
    highs = 0;
    for (int i = 0; i < 1600; i++) begin
      highs += (led_dout === 1'b1) ? 1 : 0;
      @(negedge clk);
    end
    chk("FF0000 high cycles", highs, 640);
    chk("FF0000 rising edges", rise_t.size(), 24);

    // Fill during the latch gap: 16 accepted, 17th held until the next pop.
    for (int i = 0; i < 16; i++) push(24'($urandom), 1'b0);
    chk("full fifo_level", fifo_level, 16);
    chk("full pix_ready", pix_ready, 0);
    push(24'($urandom), 1'b1);
    chk("17th accepted level", fifo_level, 16);
    if (rise_t.size() >= 25) chk("frame-to-frame first rise gap", rise_t[24] - rise_t[0], 16513);
    else chk("second frame started", rise_t.size(), 25);

    // Reset during HIGH of bit 5 of the second frame.
    g = 0;
    while (rise_t.size() < 30 && g < 2000) begin @(negedge clk); g++; end
    chk("reached bit 5 high", led_dout, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid-frame reset led_dout", led_dout, 0);
    chk("mid-frame reset fifo_level", fifo_level, 0);
    chk("mid-frame reset busy", busy, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 3-pixel frame, prefilled back-to-back.
    rise_t.delete();
    under_t.delete();
    push(24'($urandom), 1'b0);
    push(24'($urandom), 1'b0);
    push(24'($urandom), 1'b1);
    wait_idle(25000);
    chk("3-pixel rising edges", rise_t.size(), 72);
    bad = 0;
    for (int i = 1; i < rise_t.size(); i++) if (rise_t[i] - rise_t[i-1] != BITC) bad++;
    chk("3-pixel rise spacing errors", bad, 0);
    chk("3-pixel underruns", under_t.size(), 0);

    // Two pixels, last never set: underrun after bit 47.
    rise_t.delete();
    under_t.delete();
    push(24'($urandom), 1'b0);
    push(24'($urandom), 1'b0);
    wait_idle(25000);
    chk("underrun frame rising edges", rise_t.size(), 48);
    chk("underrun pulses", under_t.size(), 1);
    if (rise_t.size() >= 48 && under_t.size() >= 1)
      chk("underrun delay after bit 47 rise", under_t[0] - rise_t[47], BITC);
    else chk("underrun timing observable", 0, 1);
`ifdef WS2812_TX_STATS_EN
    chk("stats frame_cnt", frame_cnt, 2);
    chk("stats underrun_cnt", underrun_cnt, 1);
`endif

    // Randomised pixels and gaps, some straddling the pixel boundary.
    for (int i = 0; i < 6; i++) begin
      push(24'($urandom), ($urandom_range(3) == 0));
      if ($urandom_range(9) < 6) g = $urandom_range(3);
      else g = $urandom_range(1530, 1490);
      repeat (g) @(negedge clk);
    end
    repeat (2000) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
